// File: rtl/fc_neuron_seq_if.sv
// Streaming handshake bundle for fc_neuron_seq.
// Beat input (valid/ready) and result output (valid/ready).
interface fc_neuron_seq_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 23
);
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES-1:0][WIDTH-1:0]   in_x;
  logic [LANES-1:0][WIDTH-1:0]   in_w;
  logic signed [ACC_W-1:0]       bias;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_W-1:0]              out_z;

  modport master (
    output in_valid, in_x, in_w, bias, out_ready,
    input  in_ready, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_w, bias, out_ready,
    output in_ready, out_valid, out_z
  );
endinterface

// File: rtl/fc_neuron_seq.sv
// Sequential fully-connected neuron: LANES MACs per beat,
// two-stage pipeline, bias on first beat, optional ReLU.
module fc_neuron_seq #(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int LANES   = 4,
  parameter int RELU_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  fc_neuron_seq_if.slave  bus
);
  localparam int BEATS = IN / LANES;
  localparam int ACC_W = WIDTH * 2 + $clog2(IN);
  localparam int S1_W  = 2 * WIDTH + $clog2(LANES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {ACC, FLUSH, OUT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [S1_W-1:0]  sum_d;
  logic signed [S1_W-1:0]  s1_sum_q;
  logic signed [ACC_W-1:0] s1_bias_q;
  logic                    s1_vld_q, s1_first_q, s1_last_q;
  logic signed [ACC_W-1:0] acc_q;
  logic                    done_q;
  logic [ACC_W-1:0]        z_q;
  logic [ACC_W-1:0]        z_d;
  logic                    accept, first, last;
  logic                    in_ready, out_valid;

  assign accept = bus.in_valid && (state_q == ACC);
  assign first  = (cnt_q == '0);
  assign last   = (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_d  = last ? '0 : cnt_q + 1'b1;

  // Lane products summed with sign extension to stage-1 width.
  always_comb begin
    logic signed [2*WIDTH-1:0] p;
    sum_d = '0;
    p     = '0;
    for (int i = 0; i < LANES; i++) begin
      p     = $signed({1'b0, bus.in_x[i]}) * $signed(bus.in_w[i]);
      sum_d = sum_d + S1_W'(p);
    end
  end

  // Beat counter advances only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (accept) cnt_q <= cnt_d;
  end

  // Stage 1: register the beat sum with its first/last tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_sum_q   <= '0;
      s1_bias_q  <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_sum_q   <= sum_d;
        s1_bias_q  <= bus.bias;
        s1_first_q <= first;
        s1_last_q  <= last;
      end
    end
  end

  // Stage 2: accumulate, loading bias + sum on a first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        if (s1_first_q) acc_q <= s1_bias_q + ACC_W'(s1_sum_q);
        else            acc_q <= acc_q + ACC_W'(s1_sum_q);
      end
    end
  end

  assign z_d = (RELU_EN != 0 && acc_q[ACC_W-1]) ? '0 : acc_q;

  // Result register loads once the final sum is accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        z_q <= '0;
    else if (state_q == FLUSH && done_q) z_q <= z_d;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (accept && last) state_d = FLUSH;
      end
      FLUSH: begin
        if (done_q) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_z     = z_q;
endmodule

// File: tb/tb_fc_neuron_seq.sv
// Bench for fc_neuron_seq: directed cases plus random traffic
// against a transaction-level model, ReLU and raw instances.
module tb_fc_neuron_seq;
  localparam int WIDTH = 8;
  localparam int IN    = 8;
  localparam int LANES = 4;
  localparam int BEATS = IN / LANES;
  localparam int ACC_W = 2 * WIDTH + $clog2(IN);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                        t_valid = 1'b0;
  logic [LANES-1:0][WIDTH-1:0] t_x = '0;
  logic [LANES-1:0][WIDTH-1:0] t_w = '0;
  logic signed [ACC_W-1:0]     t_bias = '0;
  logic                        t_ordy = 1'b0;

  fc_neuron_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) if1 ();
  fc_neuron_seq_if #(.WIDTH(WIDTH), .LANES(LANES), .ACC_W(ACC_W)) if0 ();

  assign if1.in_valid  = t_valid;
  assign if1.in_x      = t_x;
  assign if1.in_w      = t_w;
  assign if1.bias      = t_bias;
  assign if1.out_ready = t_ordy;
  assign if0.in_valid  = t_valid;
  assign if0.in_x      = t_x;
  assign if0.in_w      = t_w;
  assign if0.bias      = t_bias;
  assign if0.out_ready = t_ordy;

  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  fc_neuron_seq #(.WIDTH(WIDTH), .IN(IN), .LANES(LANES), .RELU_EN(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] raw_z(longint v);
    return v[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] relu_z(longint v);
    logic signed [ACC_W-1:0] r;
    r = v[ACC_W-1:0];
    return (r < 0) ? '0 : r;
  endfunction

  // Transaction model: vector = bias + sum(x*w); result 2 cycles after last beat.
  bit     m_busy = 0;
  bit     m_outv = 0;
  int     m_beat = 0;
  int     m_cnt  = 0;
  longint m_sum  = 0;
  longint m_z    = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_outv = 0; m_beat = 0;
      m_cnt = 0; m_sum = 0; m_z = 0;
    end else if (!m_busy) begin
      if (t_valid) begin
        if (m_beat == 0) m_sum = t_bias;
        for (int l = 0; l < LANES; l++)
          m_sum += longint'(int'(t_x[l])) * longint'($signed(t_w[l]));
        m_beat++;
        if (m_beat == BEATS) begin
          m_beat = 0; m_busy = 1; m_cnt = 2;
        end
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_outv = 1; m_z = m_sum;
      end
    end else if (m_outv && t_ordy) begin
      m_outv = 0; m_busy = 0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("in_ready1", if1.in_ready, !m_busy);
    check("out_valid1", if1.out_valid, m_outv);
    check("out_z1", $signed(if1.out_z), relu_z(m_z));
    check("in_ready0", if0.in_ready, !m_busy);
    check("out_valid0", if0.out_valid, m_outv);
    check("out_z0", $signed(if0.out_z), raw_z(m_z));
  end

  task automatic beat(input logic [31:0] x, input logic [31:0] w,
                      input logic signed [ACC_W-1:0] b);
    @(negedge clk); #1;
    t_valid = 1'b1; t_x = x; t_w = w; t_bias = b;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk); #1;
      t_valid = 1'b0; t_x = $urandom; t_w = $urandom;
      t_bias = ACC_W'($urandom);
    end
  endtask

  task automatic collect(string nm, longint e1, longint e0);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!if1.out_valid && n < 10);
    check({nm, "_lat"}, n, 3);
    check({nm, "_z1"}, $signed(if1.out_z), e1);
    check({nm, "_z0"}, $signed(if0.out_z), e0);
    check({nm, "_model"}, raw_z(m_z), e0);
  endtask

  task automatic take(int hold, longint e1);
    #1; t_valid = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("bp_z", $signed(if1.out_z), e1);
      check("bp_rdy", if1.in_ready, 0);
      #1;
    end
    t_ordy = 1'b1;
    @(negedge clk);
    check("take_rdy", if1.in_ready, 1);
    check("take_vld", if1.out_valid, 0);
    #1; t_ordy = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_vld", if1.out_valid, 0);
    check("rst_z", if1.out_z, 0);
    check("rst_rdy", if1.in_ready, 1);
    #1; rst_n = 1'b1;

    beat(32'h01010101, 32'h01010101, 0);
    beat(32'h01010101, 32'h01010101, 0);
    collect("unit", 8, 8);
    take(0, 8);

    beat(32'hFFFFFFFF, 32'h80808080, 0);
    beat(32'hFFFFFFFF, 32'h80808080, 0);
    collect("clip", 0, -261120);
    take(0, 0);

    beat(32'hFFFFFFFF, 32'h7F7F7F7F, 5);
    beat(32'hFFFFFFFF, 32'h7F7F7F7F, 77);
    collect("ext", 259085, 259085);
    take(5, 259085);

    beat(32'h04030201, 32'h08070605, 0);
    idle(3);
    beat(32'h04030201, 32'h08070605, 0);
    collect("bub", 140, 140);
    take(0, 140);

    beat(32'h09090909, 32'h09090909, 0);
    @(negedge clk); #1;
    t_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_vld", if1.out_valid, 0);
    check("mid_rst_z", if0.out_z, 0);
    #1; rst_n = 1'b1;
    beat(32'h00000202, 32'h00000303, 0);
    beat(32'h00000202, 32'h00000303, 0);
    collect("midrst", 24, 24);
    take(0, 24);

    repeat (800) begin
      @(negedge clk); #1;
      t_valid = ($urandom % 3) != 0;
      t_x     = $urandom;
      t_w     = $urandom;
      t_bias  = ACC_W'(int'($urandom_range(0, 2000)) - 1000);
      t_ordy  = $urandom % 2;
      rst_n   = ($urandom % 150) != 0;
    end
    @(negedge clk); #1;
    rst_n = 1'b1; t_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
